// File: rtl/dram_read_arbiter_if.sv
// Bus bundle between the two read masters, the arbiter and the DRAM
// register table slave port.
interface dram_read_arbiter_if #(
    parameter int ADDR_SEL_BITS = 6
);
    localparam int IW = 30 - ADDR_SEL_BITS;

    logic [29:0]   i_M0_Address;
    logic          i_M0_Read;
    logic [31:0]   o_M0_ReadData;
    logic          o_M0_WaitRequest;
    logic [29:0]   i_M1_Address;
    logic          i_M1_Read;
    logic [31:0]   o_M1_ReadData;
    logic          o_M1_WaitRequest;
    logic          o_SlaveSel;
    logic [IW-1:0] o_RegAddr;
    logic [29:0]   o_AV_Address;
    logic          o_AV_Read;
    logic [31:0]   i_AV_ReadData;
    logic          i_AV_WaitRequest;

    // The arbiter masters the table, so it owns the master view.
    modport master (
        input  i_M0_Address, i_M0_Read, i_M1_Address, i_M1_Read,
        input  i_AV_ReadData, i_AV_WaitRequest,
        output o_M0_ReadData, o_M0_WaitRequest,
        output o_M1_ReadData, o_M1_WaitRequest,
        output o_SlaveSel, o_RegAddr, o_AV_Address, o_AV_Read
    );

    // Environment view: the requesting masters and the table slave.
    modport slave (
        output i_M0_Address, i_M0_Read, i_M1_Address, i_M1_Read,
        output i_AV_ReadData, i_AV_WaitRequest,
        input  o_M0_ReadData, o_M0_WaitRequest,
        input  o_M1_ReadData, o_M1_WaitRequest,
        input  o_SlaveSel, o_RegAddr, o_AV_Address, o_AV_Read
    );
endinterface

// File: rtl/dram_read_arbiter.sv
// Round-robin two-master read arbiter and sequencer for the DRAM
// register table; one read in flight, out-of-range indices return 0.
module dram_read_arbiter #(
    parameter int ADDR_SEL_BITS = 6,
    parameter int DEPTH         = 32
) (
    input logic                 i_Clk,
    input logic                 i_Reset,
    dram_read_arbiter_if.master bus
);
    localparam int IW = 30 - ADDR_SEL_BITS;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t        state;
    state_t        state_nx;
    logic          last;
    logic          grant;
    logic [29:0]   addr_q;
    logic [31:0]   capture;
    logic          req;
    logic          win;
    logic [29:0]   win_addr;
    logic [IW-1:0] win_idx;
    logic          in_range;

    // Round-robin winner and range check of its index.
    always_comb begin
        req      = bus.i_M0_Read | bus.i_M1_Read;
        win      = (bus.i_M0_Read & bus.i_M1_Read) ? ~last : ~bus.i_M0_Read;
        win_addr = win ? bus.i_M1_Address : bus.i_M0_Address;
        win_idx  = win_addr[IW-1:0];
        in_range = ({{(32-IW){1'b0}}, win_idx} < 32'(DEPTH));
    end

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req) state_nx = in_range ? ISSUE : RESP;
            ISSUE:   if (!bus.i_AV_WaitRequest) state_nx = CAPTURE;
            CAPTURE: state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant latch, address latch, captured word and last-grant pointer.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            last    <= 1'b1;
            grant   <= 1'b0;
            addr_q  <= '0;
            capture <= '0;
        end else begin
            if (state == IDLE && req) begin
                grant  <= win;
                addr_q <= win_addr;
                if (!in_range) capture <= '0;
            end
            if (state == CAPTURE) capture <= bus.i_AV_ReadData;
            if (state == RESP)    last    <= grant;
        end
    end

    // Slave strobes and master responses, decoded from registered state.
    always_comb begin
        bus.o_SlaveSel       = 1'b0;
        bus.o_AV_Read        = 1'b0;
        bus.o_AV_Address     = '0;
        bus.o_RegAddr        = '0;
        bus.o_M0_ReadData    = '0;
        bus.o_M1_ReadData    = '0;
        bus.o_M0_WaitRequest = bus.i_M0_Read;
        bus.o_M1_WaitRequest = bus.i_M1_Read;
        if (state == ISSUE) begin
            bus.o_SlaveSel   = 1'b1;
            bus.o_AV_Read    = 1'b1;
            bus.o_AV_Address = addr_q;
            bus.o_RegAddr    = addr_q[IW-1:0];
        end
        if (state == RESP && !grant) begin
            bus.o_M0_ReadData    = capture;
            bus.o_M0_WaitRequest = 1'b0;
        end
        if (state == RESP && grant) begin
            bus.o_M1_ReadData    = capture;
            bus.o_M1_WaitRequest = 1'b0;
        end
    end
endmodule

// File: tb/tb_dram_read_arbiter.sv
// Testbench for dram_read_arbiter: directed scenarios plus a randomized
// run against a transaction-level latency/round-robin model.
module tb_dram_read_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic av_wait;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] tbl [32];

    always #5 clk = ~clk;

    dram_read_arbiter_if #(.ADDR_SEL_BITS(6)) bus ();

    dram_read_arbiter #(.ADDR_SEL_BITS(6), .DEPTH(32)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    assign bus.i_AV_WaitRequest = av_wait;

    // Table slave: registered data, valid the cycle after an accepted read.
    always @(posedge clk)
        if (bus.o_AV_Read && !bus.i_AV_WaitRequest)
            bus.i_AV_ReadData <= tbl[bus.o_RegAddr[4:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.i_M0_Read = 1'b0;
        bus.i_M1_Read = 1'b0;
        av_wait = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [29:0] rand_addr();
        logic [23:0] i;
        logic [5:0]  u;
        u = 6'($urandom);
        if ($urandom_range(0, 3) == 0) i = 24'($urandom_range(32, 24'hFFFFFF));
        else i = 24'($urandom_range(0, 31));
        return {u, i};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        av_wait = 1'b0;
        bus.i_M0_Read = 1'b1;
        bus.i_M0_Address = 30'h5;
        bus.i_M1_Read = 1'b0;
        bus.i_M1_Address = 30'h0;
        tick();
        #1;
        total++;
        if ({bus.o_SlaveSel, bus.o_AV_Read} !== 2'b00) begin
            bad++;
            $display("FAIL reset_strobes got %b exp 00", {bus.o_SlaveSel, bus.o_AV_Read});
        end
        total++;
        if (bus.o_AV_Address !== 30'h0 || bus.o_RegAddr !== 24'h0) begin
            bad++;
            $display("FAIL reset_addr got %h/%h exp 0", bus.o_AV_Address, bus.o_RegAddr);
        end
        total++;
        if (bus.o_M0_WaitRequest !== 1'b1 || bus.o_M1_WaitRequest !== 1'b0) begin
            bad++;
            $display("FAIL reset_wait got %b%b exp 10", bus.o_M0_WaitRequest, bus.o_M1_WaitRequest);
        end
        total++;
        if (bus.o_M0_ReadData !== 32'h0 || bus.o_M1_ReadData !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got %h/%h exp 0", bus.o_M0_ReadData, bus.o_M1_ReadData);
        end
        rst = 1'b0;
        bus.i_M0_Read = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        logic e_sel, e_w0;
        logic [31:0] e_d0;
        bus.i_M0_Address = 30'h3;
        bus.i_M0_Read = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            #1;
            e_sel = (c == 1);
            e_w0 = (c != 3);
            e_d0 = (c == 3) ? 32'h00239a95 : 32'h0;
            total++;
            if (bus.o_SlaveSel !== e_sel || bus.o_AV_Read !== e_sel) begin
                bad++;
                $display("FAIL single_strobe c=%0d got %b%b exp %b", c, bus.o_SlaveSel, bus.o_AV_Read, e_sel);
            end
            total++;
            if (bus.o_RegAddr !== (e_sel ? 24'd3 : 24'd0)) begin
                bad++;
                $display("FAIL single_regaddr c=%0d got %h", c, bus.o_RegAddr);
            end
            total++;
            if (bus.o_M0_WaitRequest !== e_w0 || bus.o_M0_ReadData !== e_d0) begin
                bad++;
                $display("FAIL single_m0 c=%0d got %b %h exp %b %h", c, bus.o_M0_WaitRequest, bus.o_M0_ReadData, e_w0, e_d0);
            end
            total++;
            if (bus.o_M1_WaitRequest !== 1'b0 || bus.o_M1_ReadData !== 32'h0) begin
                bad++;
                $display("FAIL single_m1 c=%0d got %b %h exp 0 0", c, bus.o_M1_WaitRequest, bus.o_M1_ReadData);
            end
            if (c == 3) bus.i_M0_Read = 1'b0;
            tick();
        end
    endtask

    task automatic test_contention;
        logic r0, r1;
        logic e_w0, e_w1;
        logic [31:0] e_d0, e_d1;
        do_reset();
        bus.i_M0_Address = 30'h0;
        bus.i_M1_Address = 30'h1;
        r0 = 1'b1;
        r1 = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            if (c == 4 || c == 12) r0 = 1'b0;
            if (c == 8) r0 = 1'b1;
            bus.i_M0_Read = r0;
            bus.i_M1_Read = r1;
            #1;
            e_w0 = r0 && !(c == 3 || c == 11);
            e_w1 = r1 && !(c == 7 || c == 15);
            e_d0 = (c == 3 || c == 11) ? 32'h20000000 : 32'h0;
            e_d1 = (c == 7 || c == 15) ? 32'h20000800 : 32'h0;
            total++;
            if (bus.o_M0_WaitRequest !== e_w0 || bus.o_M0_ReadData !== e_d0) begin
                bad++;
                $display("FAIL contend_m0 c=%0d got %b %h exp %b %h", c, bus.o_M0_WaitRequest, bus.o_M0_ReadData, e_w0, e_d0);
            end
            total++;
            if (bus.o_M1_WaitRequest !== e_w1 || bus.o_M1_ReadData !== e_d1) begin
                bad++;
                $display("FAIL contend_m1 c=%0d got %b %h exp %b %h", c, bus.o_M1_WaitRequest, bus.o_M1_ReadData, e_w1, e_d1);
            end
            total++;
            if (bus.o_SlaveSel !== (c % 4 == 1)) begin
                bad++;
                $display("FAIL contend_sel c=%0d got %b", c, bus.o_SlaveSel);
            end
            tick();
        end
        bus.i_M1_Read = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range;
        bus.i_M1_Address = {6'h15, 24'd40};
        bus.i_M1_Read = 1'b1;
        for (int c = 0; c <= 1; c++) begin
            #1;
            total++;
            if (bus.o_SlaveSel !== 1'b0 || bus.o_AV_Read !== 1'b0) begin
                bad++;
                $display("FAIL oor_strobe c=%0d got %b%b exp 00", c, bus.o_SlaveSel, bus.o_AV_Read);
            end
            total++;
            if (bus.o_M1_WaitRequest !== (c != 1) || bus.o_M1_ReadData !== 32'h0) begin
                bad++;
                $display("FAIL oor_m1 c=%0d got %b %h", c, bus.o_M1_WaitRequest, bus.o_M1_ReadData);
            end
            if (c == 1) bus.i_M1_Read = 1'b0;
            tick();
        end
    endtask

    task automatic test_slave_wait;
        logic e_sel;
        bus.i_M0_Address = 30'h5;
        bus.i_M0_Read = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            av_wait = (c == 1 || c == 2);
            #1;
            e_sel = (c >= 1 && c <= 3);
            total++;
            if (bus.o_SlaveSel !== e_sel || bus.o_RegAddr !== (e_sel ? 24'd5 : 24'd0)) begin
                bad++;
                $display("FAIL wait_issue c=%0d got %b %h exp %b", c, bus.o_SlaveSel, bus.o_RegAddr, e_sel);
            end
            total++;
            if (bus.o_M0_WaitRequest !== (c != 5) || bus.o_M0_ReadData !== ((c == 5) ? tbl[5] : 32'h0)) begin
                bad++;
                $display("FAIL wait_m0 c=%0d got %b %h", c, bus.o_M0_WaitRequest, bus.o_M0_ReadData);
            end
            if (c == 5) bus.i_M0_Read = 1'b0;
            tick();
        end
        av_wait = 1'b0;
    endtask

    task automatic test_reset_mid_issue;
        logic r0;
        logic e_sel;
        bus.i_M0_Address = 30'h2;
        bus.i_M1_Address = 30'h7;
        r0 = 1'b1;
        bus.i_M1_Read = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c == 6) r0 = 1'b0;
            bus.i_M0_Read = r0;
            rst = (c == 1);
            #1;
            e_sel = (c == 1 || c == 3 || c == 7);
            total++;
            if (bus.o_SlaveSel !== e_sel || bus.o_AV_Read !== e_sel) begin
                bad++;
                $display("FAIL rstmid_strobe c=%0d got %b%b exp %b", c, bus.o_SlaveSel, bus.o_AV_Read, e_sel);
            end
            if (c == 2) begin
                total++;
                if (bus.o_AV_Address !== 30'h0 || bus.o_RegAddr !== 24'h0) begin
                    bad++;
                    $display("FAIL rstmid_addr got %h/%h exp 0", bus.o_AV_Address, bus.o_RegAddr);
                end
            end
            if (c >= 2) begin
                total++;
                if (bus.o_M0_WaitRequest !== (r0 && c != 5) || bus.o_M0_ReadData !== ((c == 5) ? tbl[2] : 32'h0)) begin
                    bad++;
                    $display("FAIL rstmid_m0 c=%0d got %b %h", c, bus.o_M0_WaitRequest, bus.o_M0_ReadData);
                end
                total++;
                if (bus.o_M1_WaitRequest !== (c != 9) || bus.o_M1_ReadData !== ((c == 9) ? tbl[7] : 32'h0)) begin
                    bad++;
                    $display("FAIL rstmid_m1 c=%0d got %b %h", c, bus.o_M1_WaitRequest, bus.o_M1_ReadData);
                end
            end
            if (c == 9) bus.i_M1_Read = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_word [3];
        logic e_w0;
        logic [31:0] e_d0;
        exp_word[0] = 32'h2077654e;
        exp_word[1] = 32'h6f6c6f43;
        exp_word[2] = 32'h53207275;
        bus.i_M0_Read = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            bus.i_M0_Address = 30'(4 + c / 4);
            #1;
            e_w0 = (c % 4 != 3);
            e_d0 = e_w0 ? 32'h0 : exp_word[c / 4];
            total++;
            if (bus.o_M0_WaitRequest !== e_w0 || bus.o_M0_ReadData !== e_d0) begin
                bad++;
                $display("FAIL b2b_m0 c=%0d got %b %h exp %b %h", c, bus.o_M0_WaitRequest, bus.o_M0_ReadData, e_w0, e_d0);
            end
            if (c == 11) bus.i_M0_Read = 1'b0;
            tick();
        end
    endtask

    task automatic test_random;
        logic rd [2];
        logic [29:0] ad [2];
        logic served [2];
        logic mlast, mbusy, mg, minr, issue, resp;
        int mel, mst, mresp;
        logic [29:0] ma;
        logic [31:0] md;
        do_reset();
        mlast = 1'b1;
        mbusy = 1'b0;
        mg = 1'b0;
        minr = 1'b0;
        mel = 0;
        mst = 0;
        mresp = 0;
        ma = '0;
        md = '0;
        for (int x = 0; x < 2; x++) begin
            rd[x] = 1'b0;
            ad[x] = '0;
            served[x] = 1'b0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int x = 0; x < 2; x++) begin
                if (served[x]) begin
                    rd[x] = 1'($urandom_range(0, 1));
                    if (rd[x]) ad[x] = rand_addr();
                    served[x] = 1'b0;
                end else if (!rd[x] && $urandom_range(0, 2) == 0) begin
                    rd[x] = 1'b1;
                    ad[x] = rand_addr();
                end
            end
            bus.i_M0_Read = rd[0];
            bus.i_M0_Address = ad[0];
            bus.i_M1_Read = rd[1];
            bus.i_M1_Address = ad[1];
            if (!mbusy) begin
                if (rd[0] || rd[1]) begin
                    mg = (rd[0] && rd[1]) ? !mlast : rd[1];
                    ma = ad[mg];
                    minr = (ma[23:0] < 24'd32);
                    mst = minr ? $urandom_range(0, 2) : 0;
                    mresp = minr ? 3 + mst : 1;
                    md = minr ? tbl[ma[4:0]] : 32'h0;
                    mbusy = 1'b1;
                    mel = 0;
                end
            end else begin
                mel++;
            end
            issue = mbusy && minr && mel >= 1 && mel <= 1 + mst;
            resp = mbusy && mel == mresp;
            av_wait = issue && mel <= mst;
            #1;
            total++;
            if (bus.o_SlaveSel !== issue || bus.o_AV_Read !== issue) begin
                bad++;
                $display("FAIL rand_strobe n=%0d got %b%b exp %b", n, bus.o_SlaveSel, bus.o_AV_Read, issue);
            end
            total++;
            if (bus.o_AV_Address !== (issue ? ma : 30'h0) || bus.o_RegAddr !== (issue ? ma[23:0] : 24'h0)) begin
                bad++;
                $display("FAIL rand_addr n=%0d got %h/%h exp %h", n, bus.o_AV_Address, bus.o_RegAddr, ma);
            end
            total++;
            if (bus.o_M0_WaitRequest !== (rd[0] && !(resp && !mg)) || bus.o_M0_ReadData !== ((resp && !mg) ? md : 32'h0)) begin
                bad++;
                $display("FAIL rand_m0 n=%0d got %b %h exp data %h", n, bus.o_M0_WaitRequest, bus.o_M0_ReadData, md);
            end
            total++;
            if (bus.o_M1_WaitRequest !== (rd[1] && !(resp && mg)) || bus.o_M1_ReadData !== ((resp && mg) ? md : 32'h0)) begin
                bad++;
                $display("FAIL rand_m1 n=%0d got %b %h exp data %h", n, bus.o_M1_WaitRequest, bus.o_M1_ReadData, md);
            end
            if (resp) begin
                served[mg] = 1'b1;
                mlast = mg;
                mbusy = 1'b0;
            end
            tick();
        end
        bus.i_M0_Read = 1'b0;
        bus.i_M1_Read = 1'b0;
        av_wait = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tbl[i] = $urandom;
        tbl[0] = 32'h20000000;
        tbl[1] = 32'h20000800;
        tbl[3] = 32'h00239a95;
        tbl[4] = 32'h2077654e;
        tbl[5] = 32'h6f6c6f43;
        tbl[6] = 32'h53207275;
        test_reset();
        test_single_read();
        test_contention();
        test_out_of_range();
        test_slave_wait();
        test_reset_mid_issue();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
